ps2_pos_tracker_funcmod: RTL and testbench

//   Parametrised PS/2 mouse position tracker. Accepts decoded 3/4-byte mouse packets

---
 rtl/ps2_pos_tracker_funcmod_if.sv | 27 ++
 rtl/ps2_pos_tracker_funcmod.sv | 137 +++++++++++++
 tb/tb_ps2_pos_tracker_funcmod.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pos_tracker_funcmod_if.sv
// Packet / preset / position bus between the PS/2 receive path and the tracker.
interface ps2_pos_tracker_funcmod_if #(
  parameter int POS_W = 10
);
  logic             iTrig;
  logic [31:0]      iData;
  logic             iSet;
  logic [POS_W-1:0] iSetX;
  logic [POS_W-1:0] iSetY;
  logic             oTrig;
  logic             oBusy;
  logic [POS_W-1:0] oX;
  logic [POS_W-1:0] oY;
  logic [7:0]       oZ;
  logic [2:0]       oBtn;
  logic [1:0]       oOvf;

  modport master (
    output iTrig, iData, iSet, iSetX, iSetY,
    input  oTrig, oBusy, oX, oY, oZ, oBtn, oOvf
  );

  modport slave (
    input  iTrig, iData, iSet, iSetX, iSetY,
    output oTrig, oBusy, oX, oY, oZ, oBtn, oOvf
  );
endinterface

// File: rtl/ps2_pos_tracker_funcmod.sv
// PS/2 mouse position tracker: accumulates packet deltas into clamped X/Y and a
// saturating wheel counter. IDLE -> ADD -> CLAMP -> DONE, one cycle per state.
module ps2_pos_tracker_funcmod #(
  parameter int POS_W    = 10,
  parameter int X_MAX    = 999,
  parameter int Y_MAX    = 999,
  parameter int SHIFT    = 0,
  parameter int Y_INVERT = 0,
  parameter int WHEEL_EN = 1
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  ps2_pos_tracker_funcmod_if.slave   bus
);

  // Sum width: position plus a 9-bit delta scaled by SHIFT, with sign headroom.
  localparam int DW = POS_W + SHIFT + 2;
  localparam logic [POS_W-1:0]     XMAX_U = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]     YMAX_U = POS_W'(Y_MAX);
  localparam logic signed [DW-1:0] XMAX_S = DW'(X_MAX);
  localparam logic signed [DW-1:0] YMAX_S = DW'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ADD, CLAMP, DONE} state_t;

  state_t               state, nextState;
  logic                 busy, presetEn, captureEn, addEn, clampEn;
  logic [31:0]          pkt;
  logic signed [DW-1:0] xRaw, yRaw, dX, dY, xExt, yExt, sumX, sumY;
  logic signed [8:0]    zSum;
  logic [7:0]           zSat;
  logic [POS_W-1:0]     xClamp, yClamp, xReg, yReg;
  logic [7:0]           zReg;
  logic [2:0]           btnReg;
  logic [1:0]           ovfReg;
  logic                 trigReg;
  logic                 unusedFlag;

  // Flag bit 3 is the PS/2 always-one marker; it carries no information here.
  assign unusedFlag = pkt[3];

  // State register
  always_ff @(posedge CLOCK) begin
    if (!RESET) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state: a preset in IDLE pre-empts a packet arriving in the same cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!bus.iSet && bus.iTrig) nextState = ADD;
      ADD:     nextState = CLAMP;
      CLAMP:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output / enable decode; requests outside IDLE are dropped
  always_comb begin
    busy      = (state != IDLE);
    presetEn  = (state == IDLE) && bus.iSet;
    captureEn = (state == IDLE) && !bus.iSet && bus.iTrig;
    addEn     = (state == ADD);
    clampEn   = (state == CLAMP);
  end

  // Scaled, optionally inverted deltas; an overflowed axis contributes nothing
  always_comb begin
    xRaw = {{(DW-9){pkt[4]}}, pkt[4], pkt[15:8]}  <<< SHIFT;
    yRaw = {{(DW-9){pkt[5]}}, pkt[5], pkt[23:16]} <<< SHIFT;
    dX   = pkt[6] ? '0 : xRaw;
    dY   = pkt[7] ? '0 : ((Y_INVERT != 0) ? -yRaw : yRaw);
    xExt = $signed({{(DW-POS_W){1'b0}}, xReg});
    yExt = $signed({{(DW-POS_W){1'b0}}, yReg});
  end

  // Clamp sums into the screen window and saturate the wheel to a signed byte
  always_comb begin
    if (sumX[DW-1])          xClamp = '0;
    else if (sumX > XMAX_S)  xClamp = XMAX_U;
    else                     xClamp = sumX[POS_W-1:0];
    if (sumY[DW-1])          yClamp = '0;
    else if (sumY > YMAX_S)  yClamp = YMAX_U;
    else                     yClamp = sumY[POS_W-1:0];
    case ({zSum[8], zSum[7]})
      2'b01:   zSat = 8'h7F;
      2'b10:   zSat = 8'h80;
      default: zSat = zSum[7:0];
    endcase
  end

  // Datapath: packet capture, full-width sums, and the single output write point
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      pkt     <= '0;
      sumX    <= '0;
      sumY    <= '0;
      zSum    <= '0;
      xReg    <= '0;
      yReg    <= '0;
      zReg    <= '0;
      btnReg  <= '0;
      ovfReg  <= '0;
      trigReg <= 1'b0;
    end else begin
      trigReg <= (state == DONE);
      if (presetEn) begin
        xReg <= (bus.iSetX > XMAX_U) ? XMAX_U : bus.iSetX;
        yReg <= (bus.iSetY > YMAX_U) ? YMAX_U : bus.iSetY;
        zReg <= '0;
      end
      if (captureEn) pkt <= bus.iData;
      if (addEn) begin
        sumX <= xExt + dX;
        sumY <= yExt + dY;
        zSum <= {zReg[7], zReg} + {pkt[31], pkt[31:24]};
      end
      if (clampEn) begin
        xReg   <= xClamp;
        yReg   <= yClamp;
        zReg   <= (WHEEL_EN != 0) ? zSat : 8'h00;
        btnReg <= pkt[2:0];
        ovfReg <= pkt[7:6];
      end
    end
  end

  assign bus.oTrig = trigReg;
  assign bus.oBusy = busy;
  assign bus.oX    = xReg;
  assign bus.oY    = yReg;
  assign bus.oZ    = zReg;
  assign bus.oBtn  = btnReg;
  assign bus.oOvf  = ovfReg;

endmodule

// File: tb/tb_ps2_pos_tracker_funcmod.sv
// Bench for the PS/2 position tracker: two instances (default, and SHIFT=2 with
// Y inversion) share one stimulus stream and are scored against a reference model.
module tb_ps2_pos_tracker_funcmod;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        iTrig = 1'b0;
  logic [31:0] iData = '0;
  logic        iSet  = 1'b0;
  logic [9:0]  iSetX = '0;
  logic [9:0]  iSetY = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x; int y; int z; int btn; int ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mX[2], mY[2], mZ[2];

  ps2_pos_tracker_funcmod_if #(.POS_W(10)) if0 ();
  ps2_pos_tracker_funcmod_if #(.POS_W(10)) if1 ();

  assign if0.iTrig = iTrig;  assign if1.iTrig = iTrig;
  assign if0.iData = iData;  assign if1.iData = iData;
  assign if0.iSet  = iSet;   assign if1.iSet  = iSet;
  assign if0.iSetX = iSetX;  assign if1.iSetX = iSetX;
  assign if0.iSetY = iSetY;  assign if1.iSetY = iSetY;

  ps2_pos_tracker_funcmod dut0 (.CLOCK(CLOCK), .RESET(RESET), .bus(if0.slave));

  ps2_pos_tracker_funcmod #(.SHIFT(2), .Y_INVERT(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .bus(if1.slave));

  always #5 CLOCK = ~CLOCK;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference model for instance k (0: plain, 1: x4 sensitivity, Y inverted)
  function automatic void modelPkt(int k, logic [31:0] d);
    int   sh;
    int   dx, dy, dz;
    exp_t e;
    sh = (k == 1) ? 2 : 0;
    dx = int'(d[15:8])  - (d[4] ? 256 : 0);
    dy = int'(d[23:16]) - (d[5] ? 256 : 0);
    if (d[6]) dx = 0;
    if (d[7]) dy = 0;
    dx = dx * (1 << sh);
    dy = dy * (1 << sh);
    if (k == 1) dy = -dy;
    dz = int'($signed(d[31:24]));
    mX[k] = clampi(mX[k] + dx, 0, 999);
    mY[k] = clampi(mY[k] + dy, 0, 999);
    mZ[k] = clampi(mZ[k] + dz, -128, 127);
    e.x = mX[k]; e.y = mY[k]; e.z = mZ[k];
    e.btn = int'(d[2:0]); e.ovf = int'(d[7:6]);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic startPkt(logic [31:0] d);
    iTrig = 1'b1;
    iData = d;
    modelPkt(0, d);
    modelPkt(1, d);
    tick();
    iTrig = 1'b0;
  endtask

  // Wait for oTrig, check latency / busy span, then pop and compare both instances
  task automatic waitTrig(int expLat, string tag);
    int   lat;
    int   bcnt;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    bcnt = int'(if0.oBusy);
    while (lat < 8 && !seen) begin
      tick();
      lat++;
      seen = if0.oTrig;
      if (!seen) bcnt += int'(if0.oBusy);
    end
    chk({tag, "_lat"}, lat, expLat);
    chk({tag, "_busy"}, bcnt, expLat);
    chk({tag, "_busyEnd"}, if0.oBusy, 0);
    chk({tag, "_trig1"}, if1.oTrig, 1);
    chk({tag, "_sb0"}, q0.size(), 1);
    chk({tag, "_sb1"}, q1.size(), 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({tag, "_x0"}, if0.oX, e.x);
      chk({tag, "_y0"}, if0.oY, e.y);
      chk({tag, "_z0"}, $signed(if0.oZ), e.z);
      chk({tag, "_btn0"}, if0.oBtn, e.btn);
      chk({tag, "_ovf0"}, if0.oOvf, e.ovf);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({tag, "_x1"}, if1.oX, e.x);
      chk({tag, "_y1"}, if1.oY, e.y);
      chk({tag, "_z1"}, $signed(if1.oZ), e.z);
    end
    tick();
    chk({tag, "_pulse"}, if0.oTrig, 0);
  endtask

  task automatic quiet(int n, string tag);
    repeat (n) begin
      tick();
      chk({tag, "_noTrig0"}, if0.oTrig, 0);
      chk({tag, "_noTrig1"}, if1.oTrig, 0);
    end
  endtask

  task automatic preset(int sx, int sy, logic withTrig);
    iSet  = 1'b1;
    iSetX = 10'(sx);
    iSetY = 10'(sy);
    iTrig = withTrig;
    iData = 32'h0000_0505;
    tick();
    iSet  = 1'b0;
    iTrig = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mX[k] = (sx > 999) ? 999 : sx;
      mY[k] = (sy > 999) ? 999 : sy;
      mZ[k] = 0;
    end
    chk("preset_x0", if0.oX, mX[0]);
    chk("preset_y0", if0.oY, mY[0]);
    chk("preset_z0", $signed(if0.oZ), 0);
    chk("preset_x1", if1.oX, mX[1]);
    chk("preset_busy", if0.oBusy, 0);
    chk("preset_trig", if0.oTrig, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin mX[k] = 0; mY[k] = 0; mZ[k] = 0; end

    // reset state
    repeat (3) tick();
    chk("rst_x", if0.oX, 0);
    chk("rst_y", if0.oY, 0);
    chk("rst_z", if0.oZ, 0);
    chk("rst_btn", if0.oBtn, 0);
    chk("rst_ovf", if0.oOvf, 0);
    chk("rst_trig", if0.oTrig, 0);
    chk("rst_busy", if0.oBusy, 0);
    chk("rst_x1", if1.oX, 0);
    RESET = 1'b1;
    tick();

    // basic packet and latency
    startPkt(32'h0005_1000);
    chk("t1_busyStart", if1.oBusy, 1);
    waitTrig(3, "t1");
    chk("t1_x16", if0.oX, 16);
    chk("t1_y5", if0.oY, 5);

    // clamp at both X bounds
    preset(3, 500, 1'b0);
    startPkt(32'h0000_F610);
    waitTrig(3, "t2a");
    chk("t2_xLow", if0.oX, 0);
    preset(990, 500, 1'b0);
    startPkt(32'h0000_3200);
    waitTrig(3, "t2b");
    chk("t2_xHigh", if0.oX, 999);

    // sensitivity and Y inversion on the second instance
    preset(100, 500, 1'b0);
    startPkt(32'h0014_0000);
    waitTrig(3, "t3a");
    chk("t3_y420", if1.oY, 420);
    startPkt(32'h0000_0020);
    waitTrig(3, "t3b");
    chk("t3_y999", if1.oY, 999);

    // overflow rejection with button capture
    startPkt(32'h007F_7FC7);
    waitTrig(3, "t4");
    chk("t4_ovf", if0.oOvf, 3);
    chk("t4_btn", if0.oBtn, 7);

    // wheel saturation
    preset(0, 0, 1'b0);
    startPkt(32'h6400_0000);
    waitTrig(3, "t5a");
    chk("t5_z100", $signed(if0.oZ), 100);
    startPkt(32'h6400_0000);
    waitTrig(3, "t5b");
    chk("t5_z127a", $signed(if0.oZ), 127);
    startPkt(32'h6400_0000);
    waitTrig(3, "t5c");
    chk("t5_z127b", $signed(if0.oZ), 127);
    startPkt(32'h8000_0000);
    waitTrig(3, "t5d");
    chk("t5_zm1", $signed(if0.oZ), -1);

    // preset wins over a same-cycle packet
    preset(1023, 7, 1'b1);
    chk("t6_x999", if0.oX, 999);
    quiet(5, "t6a");

    // packet offered while busy is dropped
    startPkt(32'h0000_0500);
    iTrig = 1'b1;
    iData = 32'h0000_6400;
    tick();
    iTrig = 1'b0;
    waitTrig(2, "t6b");
    chk("t6_x1004", if0.oX, 999);
    quiet(5, "t6c");

    // reset during ADD aborts the packet
    preset(200, 200, 1'b0);
    startPkt(32'h0000_0A00);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin mX[k] = 0; mY[k] = 0; mZ[k] = 0; end
    chk("t6_rstX", if0.oX, 0);
    chk("t6_rstBusy", if0.oBusy, 0);
    quiet(5, "t6d");
    chk("t6_rstXhold", if0.oX, 0);
    chk("t6_rstY1", if1.oY, 0);

    // random packets against the model
    for (int i = 0; i < 16; i++) begin
      startPkt($urandom);
      waitTrig(3, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
